// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types and defaults for the UART receive FIFO controller.
// Imported by the controller top and its FIFO sub-module.
package rx_fifo_ctrl_pkg;

  localparam int RXF_DEPTH  = 16;
  localparam int RXF_ADDR_W = 4;
  localparam int RXF_DATA_W = 8;

  // Ack handshake states; ACK drives the receiver clear
  typedef enum logic {
    RXF_IDLE = 1'b0,
    RXF_ACK  = 1'b1
  } rxf_state_e;

endpackage

// File: rtl/rx_fifo_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
// Owns storage, pointers, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_accept_o,
  input  logic              pop_i,
  output logic              pop_accept_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so full+pop may still push
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign push_accept_o = do_push;
  assign pop_accept_o  = do_pop;
  assign rd_data_o     = mem_q[rd_ptr_q];
  assign count_o       = count_q;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (
    @(posedge clk) disable iff (rst) count_q <= FULL_CNT);
`endif

endmodule

// File: rtl/rx_fifo_ctrl.sv
// UART receive-side consumer: acks each byte with a one-cycle clear
// and buffers it for the CPU; tracks overrun and raises a level irq.
module rx_fifo_ctrl
  import rx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = RXF_DEPTH,
  parameter int ADDR_W = RXF_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_rdy,
  input  logic [RXF_DATA_W-1:0] rx_data,
  output logic                  rx_clear,
  input  logic                  rd_en,
  output logic [RXF_DATA_W-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_W:0]       count,
  output logic                  overrun,
  input  logic                  ovr_clr,
  input  logic                  irq_en,
  output logic                  irq
);

  rxf_state_e state_q, state_d;
  logic       rx_clear_q, rx_clear_d;
  logic       overrun_q, overrun_d;
  logic       push_req, push_acc, pop_acc;
  logic       drop;

  // A byte is taken only in IDLE, where rdy has settled after the last clear
  assign push_req = (state_q == RXF_IDLE) && rx_rdy;
  assign drop     = push_req && !push_acc;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (RXF_DATA_W)
  ) u_fifo (
    .clk           (clock),
    .rst           (reset),
    .push_i        (push_req),
    .push_data_i   (rx_data),
    .push_accept_o (push_acc),
    .pop_i         (rd_en),
    .pop_accept_o  (pop_acc),
    .rd_data_o     (rd_data),
    .count_o       (count),
    .empty_o       (empty),
    .full_o        (full)
  );

  // Every captured or dropped byte earns exactly one clear cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RXF_IDLE: if (rx_rdy) state_d = RXF_ACK;
      RXF_ACK:  state_d = RXF_IDLE;
    endcase
    rx_clear_d = (state_d == RXF_ACK);
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (drop)    overrun_d = 1'b1;
  end

  // Handshake and status registers; reset abandons any pending ack
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RXF_IDLE;
      rx_clear_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_clear_q <= rx_clear_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_clear = rx_clear_q;
  assign overrun  = overrun_q;
  assign irq      = irq_en && !empty;

`ifndef SYNTHESIS
  a_clear_one_cycle: assert property (
    @(posedge clock) disable iff (reset) rx_clear |=> !rx_clear);
  a_pop_only_nonempty: assert property (
    @(posedge clock) disable iff (reset) pop_acc |-> !empty);
`endif

endmodule
